// File: rtl/cva6_hpdcache_req_arbiter.sv
// Round-robin arbiter sharing one HPDcache request port among NREQ CVA6 requesters.
// It tracks outstanding responses per requester, locks the port on an AMO, and routes responses back by SID.
module cva6_hpdcache_req_arbiter #(
  parameter int NREQ      = 4,
  parameter int REQ_W     = 128,
  parameter int RSP_W     = 64,
  parameter int MAX_OUTST = 4,
  parameter int SID_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*REQ_W-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_need_rsp_i,
  input  logic [NREQ-1:0]       req_is_amo_i,
  output logic                  cache_valid_o,
  input  logic                  cache_ready_i,
  output logic [REQ_W-1:0]      cache_data_o,
  output logic [SID_W-1:0]      cache_sid_o,
  input  logic                  rsp_valid_i,
  input  logic [SID_W-1:0]      rsp_sid_i,
  input  logic [RSP_W-1:0]      rsp_data_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  output logic [RSP_W-1:0]      rsp_data_o,
  output logic                  err_o
);

  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = 4;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                  state_q;
  logic [PTR_W-1:0]        rr_ptr_q;
  logic [PTR_W-1:0]        lock_sid_q;
  logic                    hold_q;
  logic [PTR_W-1:0]        hold_idx_q;
  logic [CNT_W-1:0]        cnt_q [NREQ];
  logic                    err_q;

  logic [NREQ-1:0]         eligible;
  logic                    all_zero;
  logic                    found;
  logic [PTR_W-1:0]        grant;
  logic                    valid;
  logic                    handshake;
  logic                    sid_ok;
  logic [NREQ-1:0]         rsp_hit;
  logic                    underflow;
  logic                    rsp_err;
  logic [NREQ-1:0]         cnt_inc;
  logic [NREQ-1:0]         cnt_dec;
  logic [SID_W-1:0]        lock_sid_ext;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end

    // An AMO may only go out once every requester has drained its responses.
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid_i[i] & (cnt_q[i] < CNT_W'(MAX_OUTST)) & (state_q == IDLE)
                  & (~req_is_amo_i[i] | all_zero);
    end

    found = 1'b0;
    grant = rr_ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && eligible[j]) begin
        found = 1'b1;
        grant = PTR_W'(j);
      end
    end

    // A stalled grant is replayed so the payload stays stable until accepted.
    if (hold_q) begin
      grant = hold_idx_q;
      found = eligible[hold_idx_q];
    end

    valid     = found & ~rst_i;
    handshake = valid & cache_ready_i;

    cache_valid_o            = valid;
    cache_data_o             = req_data_i[int'(grant)*REQ_W +: REQ_W];
    cache_sid_o              = '0;
    cache_sid_o[PTR_W-1:0]   = grant;
    req_ready_o              = '0;
    if (valid) req_ready_o[grant] = cache_ready_i;

    sid_ok    = int'(rsp_sid_i) < NREQ;
    underflow = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_hit[i] = rsp_valid_i & sid_ok & (rsp_sid_i == SID_W'(i));
      if (rsp_hit[i] && cnt_q[i] == '0) underflow = 1'b1;
      cnt_inc[i] = handshake & req_need_rsp_i[i] & (grant == PTR_W'(i));
      cnt_dec[i] = rsp_hit[i] & (cnt_q[i] != '0);
    end
    rsp_err = rsp_valid_i & (~sid_ok | underflow);

    rsp_valid_o = rst_i ? '0 : rsp_hit;
    rsp_data_o  = rsp_data_i;

    lock_sid_ext            = '0;
    lock_sid_ext[PTR_W-1:0] = lock_sid_q;
  end

  assign err_o = err_q;

  // NOTE: sequential state uses non-blocking assignments only; the counter array is reset explicitly because
  // stale counts after reset would block or mis-route requesters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_sid_q <= '0;
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      err_q      <= err_q | rsp_err;
      hold_q     <= valid & ~cache_ready_i;
      hold_idx_q <= grant;
      if (handshake) rr_ptr_q <= (grant == PTR_W'(NREQ-1)) ? '0 : grant + 1'b1;

      for (int i = 0; i < NREQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])      cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (cnt_dec[i] && !cnt_inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (handshake && req_is_amo_i[grant]) begin
            state_q    <= LOCKED;
            lock_sid_q <= grant;
          end
        end
        LOCKED: begin
          if (rsp_valid_i && rsp_sid_i == lock_sid_ext) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
